// File: rtl/branch_predict_unit_if.sv
// Decode/resolve handshake bundle between the pipeline and the branch predictor.
// Pipeline side is master; the predictor is slave.
interface branch_predict_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             dec_valid;
    logic [XLEN-1:0]  dec_pc;
    logic [31:0]      instr;
    logic             res_valid;
    logic [6:0]       res_op;
    logic             res_taken;
    logic [XLEN-1:0]  predict_pc;
    logic             pred_taken;
    logic             flush;
    logic [XLEN-1:0]  correct_pc;
    logic [CNT_W-1:0] total_branches;
    logic [CNT_W-1:0] times_wrong;

    modport master (
        output stall, dec_valid, dec_pc, instr, res_valid, res_op, res_taken,
        input  predict_pc, pred_taken, flush, correct_pc, total_branches, times_wrong
    );

    modport slave (
        input  stall, dec_valid, dec_pc, instr, res_valid, res_op, res_taken,
        output predict_pc, pred_taken, flush, correct_pc, total_branches, times_wrong
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Bimodal/gshare 2-bit PHT predictor: predicts conditional branches in decode, resolves them later.
// Latency: prediction combinational; resolve RESOLVE_LAT cycles after decode; flush combinational.
// Backpressure: stall freezes the metadata pipe, PHT, history and counters; no internal backpressure.
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int IDX_W       = 6,
    parameter int GHR_W       = 0,
    parameter int RESOLVE_LAT = 2,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predict_unit_if.slave bus
);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam int         PHT_N     = 2 ** IDX_W;
    // History is held IDX_W wide with bits above GHR_W forced to zero; 0 means bimodal.
    localparam logic [IDX_W-1:0] GHR_MASK = IDX_W'((64'd1 << GHR_W) - 64'd1);

    typedef struct packed {
        logic             v;
        logic             is_br;
        logic             pred_taken;
        logic [IDX_W-1:0] idx;
        logic [XLEN-1:0]  alt_pc;
    } meta_t;

    logic [1:0]       pht [PHT_N];
    logic [IDX_W-1:0] ghr;
    meta_t            meta [RESOLVE_LAT];
    meta_t            tail;
    meta_t            stage0;
    logic [CNT_W-1:0] total_branches;
    logic [CNT_W-1:0] times_wrong;

    logic             is_br;
    logic             pred;
    logic [IDX_W-1:0] idx;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  pc_target;
    logic             rb;
    logic             flush;
    logic [1:0]       pht_cur;
    logic [1:0]       pht_nxt;
    logic             unused_instr_bits;

    assign unused_instr_bits = ^bus.instr[24:12];

    always_comb begin
        is_br     = bus.dec_valid && (bus.instr[6:0] == OP_BRANCH);
        imm       = {{(XLEN-13){bus.instr[31]}}, bus.instr[31], bus.instr[7],
                     bus.instr[30:25], bus.instr[11:8], 1'b0};
        idx       = bus.dec_pc[IDX_W+1:2] ^ ghr;
        pred      = is_br && pht[idx][1];
        pc_plus4  = bus.dec_pc + XLEN'(4);
        pc_target = bus.dec_pc + imm;
    end

    assign tail = meta[RESOLVE_LAT-1];
    assign rb   = tail.v && tail.is_br && bus.res_valid && (bus.res_op == OP_BRANCH);
    assign flush = rb && (tail.pred_taken != bus.res_taken) && !bus.stall;

    // A decode arriving in the flush cycle is on the wrong path, so it enters the pipe invalid.
    always_comb begin
        stage0.v          = bus.dec_valid && !flush;
        stage0.is_br      = is_br;
        stage0.pred_taken = pred;
        stage0.idx        = idx;
        stage0.alt_pc     = pred ? pc_plus4 : pc_target;
    end

    assign pht_cur = pht[tail.idx];
    always_comb begin
        pht_nxt = pht_cur;
        if (bus.res_taken && pht_cur != 2'b11) begin
            pht_nxt = pht_cur + 2'd1;
        end else if (!bus.res_taken && pht_cur != 2'b00) begin
            pht_nxt = pht_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht[i] <= 2'b01;
            end
            for (int s = 0; s < RESOLVE_LAT; s++) begin
                meta[s] <= '0;
            end
            ghr            <= '0;
            total_branches <= '0;
            times_wrong    <= '0;
        end else if (!bus.stall) begin
            meta[0] <= stage0;
            for (int s = 1; s < RESOLVE_LAT; s++) begin
                meta[s] <= meta[s-1];
                if (flush) begin
                    meta[s].v <= 1'b0;
                end
            end
            if (rb) begin
                pht[tail.idx] <= pht_nxt;
                ghr           <= {ghr[IDX_W-2:0], bus.res_taken} & GHR_MASK;
                if (total_branches != '1) begin
                    total_branches <= total_branches + CNT_W'(1);
                end
                if (flush && times_wrong != '1) begin
                    times_wrong <= times_wrong + CNT_W'(1);
                end
            end
        end
    end

    assign bus.pred_taken     = pred;
    assign bus.predict_pc     = pred ? pc_target : pc_plus4;
    assign bus.flush          = flush;
    assign bus.correct_pc     = tail.v ? tail.alt_pc : '0;
    assign bus.total_branches = total_branches;
    assign bus.times_wrong    = times_wrong;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench: bimodal instance (dut0) driven from a vector table plus stall/reset sequences,
// and a gshare instance (dut1, GHR_W=2, CNT_W=2) for history indexing and counter saturation.
module tb_branch_predict_unit;
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        dec_valid = 1'b0;
    logic [31:0] dec_pc = '0;
    logic [31:0] instr = '0;
    logic        res_valid = 1'b0;
    logic [6:0]  res_op = '0;
    logic        res_taken = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_predict_unit_if #(.XLEN(32), .CNT_W(16)) bus0 ();
    branch_predict_unit_if #(.XLEN(32), .CNT_W(2))  bus1 ();

    assign bus0.stall = stall;      assign bus1.stall = stall;
    assign bus0.dec_valid = dec_valid; assign bus1.dec_valid = dec_valid;
    assign bus0.dec_pc = dec_pc;    assign bus1.dec_pc = dec_pc;
    assign bus0.instr = instr;      assign bus1.instr = instr;
    assign bus0.res_valid = res_valid; assign bus1.res_valid = res_valid;
    assign bus0.res_op = res_op;    assign bus1.res_op = res_op;
    assign bus0.res_taken = res_taken; assign bus1.res_taken = res_taken;

    branch_predict_unit #(.XLEN(32), .IDX_W(6), .GHR_W(0), .RESOLVE_LAT(2), .CNT_W(16))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    branch_predict_unit #(.XLEN(32), .IDX_W(6), .GHR_W(2), .RESOLVE_LAT(2), .CNT_W(2))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic        dv;
        logic [31:0] pc;
        int          imm;
        logic        rv;
        logic        rt;
        logic        e_pt;
        logic [31:0] e_ppc;
        logic        e_fl;
        logic [31:0] e_cpc;
        logic [15:0] e_tb;
        logic [15:0] e_tw;
    } vec_t;

    localparam int NV = 31;
    vec_t tbl [NV];

    function automatic logic [31:0] beq(input int imm);
        logic [31:0] b;
        b = imm;
        return {b[12], b[10:5], 5'd0, 5'd0, 3'b000, b[4:1], b[11], OP_BR};
    endfunction

    function automatic vec_t mk(input logic dv, input logic [31:0] pc, input int imm,
                                input logic rv, input logic rt, input logic e_pt,
                                input logic [31:0] e_ppc, input logic e_fl,
                                input logic [31:0] e_cpc, input int e_tb, input int e_tw);
        vec_t v;
        v.dv = dv; v.pc = pc; v.imm = imm; v.rv = rv; v.rt = rt;
        v.e_pt = e_pt; v.e_ppc = e_ppc; v.e_fl = e_fl; v.e_cpc = e_cpc;
        v.e_tb = 16'(e_tb); v.e_tw = 16'(e_tw);
        return v;
    endfunction

    task automatic drive(input logic dv, input logic [31:0] pc, input int imm,
                         input logic rv, input logic rt, input logic st);
        dec_valid = dv;
        dec_pc    = pc;
        instr     = beq(imm);
        res_valid = rv;
        res_op    = rv ? OP_BR : 7'b0110011;
        res_taken = rt;
        stall     = st;
    endtask

    task automatic chk(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h, expected %h", name, tag, act, exp);
        end
    endtask

    task automatic chk0(input int tag, input logic e_pt, input logic [31:0] e_ppc,
                        input logic e_fl, input logic [31:0] e_cpc, input int e_tb, input int e_tw);
        chk("pred_taken", tag, 32'(bus0.pred_taken), 32'(e_pt));
        chk("predict_pc", tag, bus0.predict_pc, e_ppc);
        chk("flush", tag, 32'(bus0.flush), 32'(e_fl));
        chk("correct_pc", tag, bus0.correct_pc, e_cpc);
        chk("total_branches", tag, 32'(bus0.total_branches), 32'(e_tb));
        chk("times_wrong", tag, 32'(bus0.times_wrong), 32'(e_tw));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic p;
        int   tw_m;

        // Rows: decode BEQ (dv,pc,imm), resolve (rv,rt) -> pred_taken, predict_pc, flush, correct_pc, tb, tw
        tbl[0]  = mk(1, 32'h100, 16, 0, 0,  0, 32'h104, 0, 32'h0,   0, 0);
        tbl[1]  = mk(0, 32'h0,    0, 0, 0,  0, 32'h4,   0, 32'h0,   0, 0);
        tbl[2]  = mk(0, 32'h0,    0, 1, 1,  0, 32'h4,   1, 32'h110, 0, 0);
        tbl[3]  = mk(1, 32'h100, 16, 0, 0,  1, 32'h110, 0, 32'h0,   1, 1);
        tbl[4]  = mk(0, 32'h0,    0, 0, 0,  0, 32'h4,   0, 32'h0,   1, 1);
        tbl[5]  = mk(1, 32'h100, 16, 1, 1,  1, 32'h110, 0, 32'h104, 1, 1);
        tbl[6]  = mk(0, 32'h0,    0, 0, 0,  0, 32'h4,   0, 32'h0,   2, 1);
        tbl[7]  = mk(0, 32'h0,    0, 1, 1,  0, 32'h4,   0, 32'h104, 2, 1);
        tbl[8]  = mk(1, 32'h100, 16, 0, 0,  1, 32'h110, 0, 32'h0,   3, 1);
        tbl[9]  = mk(0, 32'h0,    0, 0, 0,  0, 32'h4,   0, 32'h0,   3, 1);
        tbl[10] = mk(0, 32'h0,    0, 1, 0,  0, 32'h4,   1, 32'h104, 3, 1);
        tbl[11] = mk(1, 32'h100, 16, 0, 0,  1, 32'h110, 0, 32'h0,   4, 2);
        tbl[12] = mk(0, 32'h0,    0, 0, 0,  0, 32'h4,   0, 32'h0,   4, 2);
        tbl[13] = mk(0, 32'h0,    0, 1, 1,  0, 32'h4,   0, 32'h104, 4, 2);
        tbl[14] = mk(1, 32'h200, -8, 0, 0,  1, 32'h1F8, 0, 32'h0,   5, 2);
        tbl[15] = mk(0, 32'h0,    0, 0, 0,  0, 32'h4,   0, 32'h0,   5, 2);
        tbl[16] = mk(0, 32'h0,    0, 1, 1,  0, 32'h4,   0, 32'h204, 5, 2);
        tbl[17] = mk(1, 32'hFFFFFFFC, 8, 0, 0, 0, 32'h0, 0, 32'h0,  6, 2);
        tbl[18] = mk(0, 32'h0,    0, 0, 0,  0, 32'h4,   0, 32'h0,   6, 2);
        tbl[19] = mk(0, 32'h0,    0, 1, 1,  0, 32'h4,   1, 32'h4,   6, 2);
        tbl[20] = mk(1, 32'hFFFFFFFC, 8, 0, 0, 1, 32'h4, 0, 32'h0,  7, 3);
        tbl[21] = mk(0, 32'h0,    0, 0, 0,  0, 32'h4,   0, 32'h0,   7, 3);
        tbl[22] = mk(0, 32'h0,    0, 1, 1,  0, 32'h4,   0, 32'h0,   7, 3);
        tbl[23] = mk(1, 32'h100, 16, 0, 0,  1, 32'h110, 0, 32'h0,   8, 3);
        tbl[24] = mk(1, 32'h104, 16, 0, 0,  0, 32'h108, 0, 32'h0,   8, 3);
        tbl[25] = mk(0, 32'h0,    0, 1, 0,  0, 32'h4,   1, 32'h104, 8, 3);
        tbl[26] = mk(0, 32'h0,    0, 1, 1,  0, 32'h4,   0, 32'h0,   9, 4);
        tbl[27] = mk(1, 32'h104, 16, 0, 0,  0, 32'h108, 0, 32'h0,   9, 4);
        tbl[28] = mk(0, 32'h0,    0, 0, 0,  0, 32'h4,   0, 32'h0,   9, 4);
        tbl[29] = mk(0, 32'h0,    0, 0, 0,  0, 32'h4,   0, 32'h114, 9, 4);
        tbl[30] = mk(0, 32'h0,    0, 0, 0,  0, 32'h4,   0, 32'h0,   9, 4);

        drive(0, 32'h0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk0(-1, 0, 32'h4, 0, 32'h0, 0, 0);
        tick();

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].dv, tbl[i].pc, tbl[i].imm, tbl[i].rv, tbl[i].rt, 1'b0);
            @(negedge clk);
            chk0(i, tbl[i].e_pt, tbl[i].e_ppc, tbl[i].e_fl, tbl[i].e_cpc, tbl[i].e_tb, tbl[i].e_tw);
            tick();
        end

        // Stall with a mispredicting branch at the tail: flush held off, state frozen.
        drive(1, 32'h104, 16, 0, 0, 0);
        @(negedge clk); chk0(100, 0, 32'h108, 0, 32'h0, 9, 4); tick();
        drive(0, 32'h0, 0, 0, 0, 0);
        tick();
        for (int s = 0; s < 3; s++) begin
            drive(1, 32'h100, 16, 1, 1, 1);
            @(negedge clk);
            chk0(101 + s, 1, 32'h110, 0, 32'h114, 9, 4);
            tick();
        end
        drive(0, 32'h0, 0, 1, 1, 0);
        @(negedge clk); chk0(104, 0, 32'h4, 1, 32'h114, 9, 4); tick();
        drive(0, 32'h0, 0, 0, 0, 0);
        @(negedge clk); chk0(105, 0, 32'h4, 0, 32'h0, 10, 5); tick();

        // Reset mid-flight (with stall high) discards the in-flight branch and the trained PHT.
        drive(1, 32'h100, 16, 0, 0, 0);
        @(negedge clk); chk0(110, 1, 32'h110, 0, 32'h0, 10, 5); tick();
        drive(0, 32'h0, 0, 0, 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1, 32'h100, 16, 1, 0, 0);
        @(negedge clk); chk0(111, 0, 32'h104, 0, 32'h0, 0, 0); tick();

        // gshare instance: fresh reset, then history T,N -> ghr=2'b10.
        drive(0, 32'h0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1, 32'h100, 16, 0, 0, 0);
        @(negedge clk); chk("g_pred_taken", 200, 32'(bus1.pred_taken), 32'd0); tick();
        drive(0, 32'h0, 0, 0, 0, 0); tick();
        drive(0, 32'h0, 0, 1, 1, 0);
        @(negedge clk); chk("g_flush", 202, 32'(bus1.flush), 32'd1); tick();
        drive(1, 32'h100, 16, 0, 0, 0);
        @(negedge clk);
        chk("g_pred_taken", 203, 32'(bus1.pred_taken), 32'd0);
        chk("g_total_branches", 203, 32'(bus1.total_branches), 32'd1);
        chk("g_times_wrong", 203, 32'(bus1.times_wrong), 32'd1);
        tick();
        drive(0, 32'h0, 0, 0, 0, 0); tick();
        drive(0, 32'h0, 0, 1, 0, 0);
        @(negedge clk); chk("g_flush", 205, 32'(bus1.flush), 32'd0); tick();
        drive(1, 32'h0, 16, 0, 0, 0);
        @(negedge clk);
        chk("g_pred_taken", 206, 32'(bus1.pred_taken), 32'd0);
        chk("g_predict_pc", 206, bus1.predict_pc, 32'h4);
        chk("g_total_branches", 206, 32'(bus1.total_branches), 32'd2);
        chk("g_times_wrong", 206, 32'(bus1.times_wrong), 32'd1);
        tick();
        drive(1, 32'h8, 16, 0, 0, 0);
        @(negedge clk);
        chk("g_pred_taken", 207, 32'(bus1.pred_taken), 32'd1);
        chk("g_predict_pc", 207, bus1.predict_pc, 32'h18);
        tick();
        drive(0, 32'h0, 0, 1, 1, 0);
        @(negedge clk);
        chk("g_flush", 208, 32'(bus1.flush), 32'd1);
        chk("g_correct_pc", 208, bus1.correct_pc, 32'h10);
        tick();
        drive(0, 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        chk("g_total_branches", 209, 32'(bus1.total_branches), 32'd3);
        chk("g_times_wrong", 209, 32'(bus1.times_wrong), 32'd2);
        tick();

        // Force three more mispredicts; 2-bit counters must stick at 3.
        tw_m = 2;
        for (int k = 0; k < 3; k++) begin
            drive(1, 32'h100, 16, 0, 0, 0);
            @(negedge clk); p = bus1.pred_taken; tick();
            drive(0, 32'h0, 0, 0, 0, 0); tick();
            drive(0, 32'h0, 0, 1, !p, 0);
            @(negedge clk); chk("g_flush", 210 + k, 32'(bus1.flush), 32'd1); tick();
            drive(0, 32'h0, 0, 0, 0, 0);
            tw_m = (tw_m == 3) ? 3 : tw_m + 1;
            @(negedge clk);
            chk("g_times_wrong", 220 + k, 32'(bus1.times_wrong), 32'(tw_m));
            chk("g_total_branches", 220 + k, 32'(bus1.total_branches), 32'd3);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
